// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM encodings, header field
// positions and the per-region word limit.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    BL_IDLE   = 3'd0,
    BL_LOAD_D = 3'd1,
    BL_LOAD_I = 3'd2,
    BL_DRAIN  = 3'd3,
    BL_DONE   = 3'd4,
    BL_ERROR  = 3'd5
  } bl_state_t;

  // Header word layout: instruction count in the upper half, data count in the lower half
  localparam int HDR_NI_LSB   = 16;
  localparam int HDR_ND_LSB   = 0;
  localparam int BL_MAX_WORDS = 256;

endpackage

// File: rtl/bl_write_port.sv
// One BRAM write port of the boot loader: word counter for its region plus a
// registered address/data/enable stage that issues each write one cycle later.
module bl_write_port
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic                  w_enb
);

  logic [CNT_WIDTH-1:0]  cnt_p0;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] dat_p1;
  logic                  vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (accept) begin
      cnt_p0 <= cnt_p0 + CNT_WIDTH'(1);
    end
  end

  // p0 -> p1: word index becomes a byte address; the BRAM sees it the cycle after transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      dat_p1  <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        addr_p1 <= {cnt_p0[ADDR_WIDTH-3:0], 2'b00};
        dat_p1  <= din;
      end
    end
  end

  assign cnt    = cnt_p0;
  assign w_addr = addr_p1;
  assign w_dat  = dat_p1;
  assign w_enb  = vld_p1;

endmodule

// File: rtl/boot_loader.sv
// Stream-fed boot loader: parses a count header, fills data BRAM then
// instruction BRAM, and releases the core once the last write has landed.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_init_done,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  error
);

  bl_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] n_i_q, n_d_q;
  logic [CNT_WIDTH-1:0] n_i_hdr, n_d_hdr;
  logic [CNT_WIDTH-1:0] i_cnt, d_cnt;
  logic                 ready_st, xfer, hdr_load;
  logic                 d_accept, i_accept, d_last, i_last;

  function automatic logic header_bad(input logic [CNT_WIDTH-1:0] ni,
                                      input logic [CNT_WIDTH-1:0] nd);
    return (ni == '0) || (ni > CNT_WIDTH'(BL_MAX_WORDS)) ||
           (nd > CNT_WIDTH'(BL_MAX_WORDS));
  endfunction

  assign n_i_hdr = s_data[HDR_NI_LSB +: CNT_WIDTH];
  assign n_d_hdr = s_data[HDR_ND_LSB +: CNT_WIDTH];

  // rst only masks the visible ready; internally everything is cleared on the edge anyway
  assign ready_st = (state_q == BL_IDLE) || (state_q == BL_LOAD_D) ||
                    (state_q == BL_LOAD_I);
  assign s_ready  = ready_st & ~rst;
  assign xfer     = s_valid & ready_st;

  assign d_last = (d_cnt + CNT_WIDTH'(1)) == n_d_q;
  assign i_last = (i_cnt + CNT_WIDTH'(1)) == n_i_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_i_q <= '0;
      n_d_q <= '0;
    end else if (hdr_load) begin
      n_i_q <= n_i_hdr;
      n_d_q <= n_d_hdr;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_load    = 1'b0;
    d_accept    = 1'b0;
    i_accept    = 1'b0;
    busy        = 1'b0;
    error       = 1'b0;
    cpu_run     = 1'b0;
    d_init_done = 1'b0;
    case (state_q)
      BL_IDLE: begin
        if (xfer) begin
          hdr_load = 1'b1;
          if (header_bad(n_i_hdr, n_d_hdr)) begin
            state_d = BL_ERROR;
          end else if (n_d_hdr == '0) begin
            state_d = BL_LOAD_I;
          end else begin
            state_d = BL_LOAD_D;
          end
        end
      end
      BL_LOAD_D: begin
        busy = 1'b1;
        if (xfer) begin
          d_accept = 1'b1;
          if (d_last) state_d = BL_LOAD_I;
        end
      end
      BL_LOAD_I: begin
        busy = 1'b1;
        if (xfer) begin
          i_accept = 1'b1;
          if (i_last) state_d = BL_DRAIN;
        end
      end
      BL_DRAIN: begin
        // the final instruction write is on the BRAM port during this cycle
        busy    = 1'b1;
        state_d = BL_DONE;
      end
      BL_DONE: begin
        cpu_run     = 1'b1;
        d_init_done = 1'b1;
        if (start) state_d = BL_IDLE;
      end
      BL_ERROR: begin
        error = 1'b1;
        if (start) state_d = BL_IDLE;
      end
      default: state_d = BL_IDLE;
    endcase
  end

  bl_write_port #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_d_port (
    .clk   (clk),
    .rst   (rst),
    .accept(d_accept),
    .clr   (d_accept & d_last),
    .din   (s_data),
    .cnt   (d_cnt),
    .w_addr(d_w_addr),
    .w_dat (d_w_dat),
    .w_enb (d_w_enb)
  );

  bl_write_port #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_i_port (
    .clk   (clk),
    .rst   (rst),
    .accept(i_accept),
    .clr   (i_accept & i_last),
    .din   (s_data),
    .cnt   (i_cnt),
    .w_addr(i_w_addr),
    .w_dat (i_w_dat),
    .w_enb (i_w_enb)
  );

endmodule
